// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the two-requester XOR arbiter.
package xor_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/OperacaoXor8Bits.sv
// Purely combinational 8-bit XOR datapath; zero latency, no flow control.
module OperacaoXor8Bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);
  assign s = a ^ b;
endmodule

// File: rtl/xor_share_arbiter.sv
// Two requesters share one XOR datapath; result registered 1 cycle after accept, round-robin on ties.
// Backpressure: readies drop while the result is held unconsumed. Option XOR_ARB_STATS_EN adds grant counters.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int DATA_W = xor_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  input  logic              res_ready
`ifdef XOR_ARB_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              sel;
  logic              grant;
  logic [DATA_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_b;
  logic [DATA_W-1:0] xor_y;

  // Grant decision never looks at operands; rst_n gating keeps readies low during reset.
  always_comb begin
    sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    grant      = rst_n & ((state == IDLE) | res_ready) & (req0_valid | req1_valid);
    req0_ready = grant & ~sel;
    req1_ready = grant & sel;
    mux_a      = sel ? req1_a : req0_a;
    mux_b      = sel ? req1_b : req0_b;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = grant ? HOLD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  OperacaoXor8Bits u_xor (
    .a (mux_a),
    .b (mux_b),
    .s (xor_y)
  );

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant) begin
      res_data   <= xor_y;
      res_id     <= sel;
      last_grant <= sel;
    end
  end

  assign res_valid = (state == HOLD);

`ifdef XOR_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      if (req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'h01;
      if (req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'h01;
    end
  end
`endif

endmodule
